rvi_bj_redirect: RTL

RVI_BJ_REDIRECT -- requirements
Module: rvi_bj_redirect

---
 rtl/rvi_bj_redirect_pkg.sv | 11 +
 rtl/rvi_sat_cnt.sv | 16 +
 rtl/rvi_bj_redirect.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rvi_bj_redirect_pkg.sv
// Shared types and constants for the branch/jump redirect block.
package rvi_bj_redirect_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REDIR = 2'd1,
      FLUSH = 2'd2
   } bjState_e;

   localparam int MAX_FLUSH_CYC = 7;
   localparam int DRAIN_W       = $clog2(MAX_FLUSH_CYC + 1);
endpackage

// File: rtl/rvi_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module rvi_sat_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + WIDTH'(1);
   end
endmodule

// File: rtl/rvi_bj_redirect.sv
// Resolves EX-stage branches against the fetch prediction and issues
// a redirect + flush sequence, or a trap pulse for misaligned targets.
module rvi_bj_redirect
   import rvi_bj_redirect_pkg::*;
#(
   parameter  int RV64      = 0,
   parameter  int RVC       = 1,
   parameter  int FLUSH_CYC = 2,
   localparam int W         = 32 * (RV64 + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         exVld,
   output logic         exRdy,
   input  logic [1:0]   exBjEn,
   input  logic [W-1:0] exTgtAddr,
   input  logic [W-1:0] exLinkPc,
   input  logic         exPredTkn,
   input  logic [W-1:0] exPredTgt,
   output logic         redirVld,
   input  logic         redirRdy,
   output logic [W-1:0] redirPc,
   output logic         flush,
   output logic         excVld,
   output logic [W-1:0] excTval,
   output logic [31:0]  bjCnt,
   output logic [31:0]  mispredCnt
);
   bjState_e           stateReg;
   logic [DRAIN_W-1:0] drainCntReg;

   logic         accept;
   logic         taken;
   logic         mispredict;
   logic         misaligned;
   logic [W-1:0] actPc;
   logic [1:0]   cntInc;
   logic [31:0]  cntVal [2];

   assign exRdy  = (stateReg == IDLE);
   assign accept = exVld && exRdy;
   assign taken  = |exBjEn;

   // Bit 0 of any instruction address is always zero.
   assign actPc      = {(taken ? exTgtAddr[W-1:1] : exLinkPc[W-1:1]), 1'b0};
   assign mispredict = (taken != exPredTkn) || (taken && (exTgtAddr != exPredTgt));
   assign misaligned = taken && (RVC == 0) && exTgtAddr[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg    <= IDLE;
         drainCntReg <= '0;
         redirVld    <= 1'b0;
         flush       <= 1'b0;
         redirPc     <= '0;
         excVld      <= 1'b0;
         excTval     <= '0;
      end else begin
         excVld <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     excVld  <= 1'b1;
                     excTval <= exTgtAddr;
                  end else if (mispredict) begin
                     stateReg <= REDIR;
                     redirVld <= 1'b1;
                     flush    <= 1'b1;
                     redirPc  <= actPc;
                  end
               end
            end
            REDIR: begin
               if (redirRdy) begin
                  redirVld <= 1'b0;
                  if (FLUSH_CYC == 0) begin
                     stateReg <= IDLE;
                     flush    <= 1'b0;
                  end else begin
                     stateReg    <= FLUSH;
                     drainCntReg <= DRAIN_W'(FLUSH_CYC);
                  end
               end
            end
            FLUSH: begin
               // Counter holds the remaining drain cycles including this one.
               if (drainCntReg <= DRAIN_W'(1)) begin
                  stateReg    <= IDLE;
                  flush       <= 1'b0;
                  drainCntReg <= '0;
               end else begin
                  drainCntReg <= drainCntReg - DRAIN_W'(1);
               end
            end
            default: begin
               stateReg <= IDLE;
               redirVld <= 1'b0;
               flush    <= 1'b0;
            end
         endcase
      end
   end

   assign cntInc = {(stateReg == REDIR) && redirRdy, accept};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gCnt
         rvi_sat_cnt #(.WIDTH(32)) uCnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (cntInc[gi]),
            .cnt  (cntVal[gi])
         );
      end
   endgenerate

   assign bjCnt      = cntVal[0];
   assign mispredCnt = cntVal[1];
endmodule
